// File: rtl/envelope_host_ctrl.sv
// envelope_host_ctrl: host-side job sequencer for the digital-envelope crypto core
module envelope_host_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int KEY_TIMEOUT  = 65535
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic         i_cmd_dir,
  input  logic [129:0] i_cmd_cmkey,
  input  logic [7:0]   i_cmd_nblk,
  input  logic         i_din_valid,
  output logic         o_din_ready,
  input  logic [127:0] i_din,
  output logic         o_dout_valid,
  output logic [127:0] o_dout,
  output logic         o_dout_last,
  output logic         o_cmkey_valid,
  output logic [129:0] o_cmkey_out,
  output logic         o_done,
  output logic         o_err,
  output logic         o_spurious,
  output logic         o_crypt_pre,
  output logic         o_den_sel,
  input  logic         i_crypt_ready,
  output logic [129:0] o_de_cmkey,
  input  logic [129:0] i_en_cmkey,
  output logic [127:0] o_blk_in,
  output logic         o_blk_in_sync,
  input  logic [127:0] i_blk_out,
  input  logic         i_blk_out_sync
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_KEY, S_STREAM, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;
  logic         r_up;
  logic [31:0]  r_timer;
  logic [7:0]   r_nblk, r_issued, r_returned;
  logic [3:0]   r_inflight;
  logic         r_dout_valid, r_dout_last, r_cmkey_valid, r_spurious, r_den_sel, r_blk_in_sync;
  logic [127:0] r_dout, r_blk_in;
  logic [129:0] r_cmkey_out, r_de_cmkey;
  logic         w_accept, w_iss, w_ret, w_last, w_key;
  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_iss    = i_din_valid && o_din_ready;
  assign w_ret    = i_blk_out_sync && (r_inflight != 4'd0);
  assign w_last   = w_ret && (r_returned + 8'd1 == r_nblk);
  assign w_key    = (r_state == S_WAIT_KEY) && i_crypt_ready;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_accept ? S_PRE : S_IDLE;
      S_PRE:      w_next = S_WAIT_KEY;
      S_WAIT_KEY: w_next = i_crypt_ready ? ((r_nblk == 8'd0) ? S_DONE : S_STREAM) :
                           (r_timer == 32'(KEY_TIMEOUT)) ? S_ERR : S_WAIT_KEY;
      S_STREAM:   w_next = w_last ? S_DONE : S_STREAM;
      default:    w_next = S_IDLE;
    endcase
  end
  // r_up keeps cmd_ready low while reset is held and for the release cycle
  always_comb begin
    o_cmd_ready = r_up && (r_state == S_IDLE);
    o_crypt_pre = r_state == S_PRE;
    o_din_ready = (r_state == S_STREAM) && (r_issued < r_nblk) && (r_inflight < 4'(MAX_INFLIGHT));
    o_done      = (r_state == S_DONE) || (r_state == S_ERR);
    o_err       = r_state == S_ERR;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_up          <= 1'b0;
      r_timer       <= '0;
      r_nblk        <= '0;
      r_issued      <= '0;
      r_returned    <= '0;
      r_inflight    <= '0;
      r_dout_valid  <= 1'b0;
      r_dout_last   <= 1'b0;
      r_cmkey_valid <= 1'b0;
      r_spurious    <= 1'b0;
      r_den_sel     <= 1'b0;
      r_blk_in_sync <= 1'b0;
      r_dout        <= '0;
      r_blk_in      <= '0;
      r_cmkey_out   <= '0;
      r_de_cmkey    <= '0;
    end else begin
      r_up          <= 1'b1;
      r_blk_in_sync <= w_iss;
      r_dout_valid  <= w_ret;
      r_dout_last   <= w_last;
      r_cmkey_valid <= w_key && !r_den_sel;
      r_timer       <= (r_state == S_PRE) ? 32'd0 :
                       (r_state == S_WAIT_KEY && !i_crypt_ready) ? r_timer + 32'd1 : r_timer;
      r_spurious    <= w_accept ? 1'b0 : (i_blk_out_sync && r_inflight == 4'd0) ? 1'b1 : r_spurious;
      if (w_accept) begin
        r_den_sel  <= i_cmd_dir;
        r_de_cmkey <= i_cmd_cmkey;
        r_nblk     <= i_cmd_nblk;
        r_issued   <= '0;
        r_returned <= '0;
        r_inflight <= '0;
      end else begin
        r_issued   <= r_issued + {7'd0, w_iss};
        r_returned <= r_returned + {7'd0, w_ret};
        r_inflight <= r_inflight + {3'd0, w_iss} - {3'd0, w_ret};
      end
      if (w_iss) r_blk_in <= i_din;
      if (w_ret) r_dout <= i_blk_out;
      if (w_key && !r_den_sel) r_cmkey_out <= i_en_cmkey;
    end
  assign o_dout_valid  = r_dout_valid;
  assign o_dout_last   = r_dout_last;
  assign o_dout        = r_dout;
  assign o_cmkey_valid = r_cmkey_valid;
  assign o_cmkey_out   = r_cmkey_out;
  assign o_spurious    = r_spurious;
  assign o_den_sel     = r_den_sel;
  assign o_de_cmkey    = r_de_cmkey;
  assign o_blk_in      = r_blk_in;
  assign o_blk_in_sync = r_blk_in_sync;
endmodule

// File: tb/tb_envelope_host_ctrl.sv
// tb_envelope_host_ctrl: random jobs against a host/core reference model
module tb_envelope_host_ctrl;
  localparam int MAXI = 4;
  localparam int KT = 50;
  localparam logic [127:0] MASK = 128'h5A5A_C3C3_0F0F_9696_A5A5_3C3C_F0F0_6969;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_dir, din_valid, din_ready, dout_valid, dout_last;
  logic cmkey_valid, done, err, spurious, crypt_pre, den_sel, crypt_ready, blk_in_sync, blk_out_sync;
  logic [129:0] cmd_cmkey, cmkey_out, de_cmkey, en_cmkey;
  logic [7:0] cmd_nblk;
  logic [127:0] din, dout, blk_in, blk_out;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  envelope_host_ctrl #(.MAX_INFLIGHT(MAXI), .KEY_TIMEOUT(KT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_dir(cmd_dir), .i_cmd_cmkey(cmd_cmkey), .i_cmd_nblk(cmd_nblk),
    .i_din_valid(din_valid), .o_din_ready(din_ready), .i_din(din),
    .o_dout_valid(dout_valid), .o_dout(dout), .o_dout_last(dout_last),
    .o_cmkey_valid(cmkey_valid), .o_cmkey_out(cmkey_out), .o_done(done), .o_err(err),
    .o_spurious(spurious), .o_crypt_pre(crypt_pre), .o_den_sel(den_sel),
    .i_crypt_ready(crypt_ready), .o_de_cmkey(de_cmkey), .i_en_cmkey(en_cmkey),
    .o_blk_in(blk_in), .o_blk_in_sync(blk_in_sync), .i_blk_out(blk_out), .i_blk_out_sync(blk_out_sync)
  );
  task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic logic [129:0] rnd130();
    return {2'($urandom_range(3)), rnd128()};
  endfunction
  task automatic idle_inputs();
    cmd_valid = 0; cmd_dir = 0; cmd_cmkey = '0; cmd_nblk = '0; din_valid = 0; din = '0;
    crypt_ready = 0; en_cmkey = '0; blk_out = '0; blk_out_sync = 0;
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_crypt_pre"}, crypt_pre, 0);
    chk({tag, "_blk_in_sync"}, blk_in_sync, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cmkey_valid"}, cmkey_valid, 0);
    chk({tag, "_den_sel"}, den_sel, 0);
    chk({tag, "_din_ready"}, din_ready, 0);
    chk({tag, "_de_cmkey"}, de_cmkey, 0);
  endtask
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
    #1 chk("rel_cmd_ready_low", cmd_ready, 0);
    @(posedge clk);
    #1 chk("rel_cmd_ready_high", cmd_ready, 1);
    chk("rel_crypt_pre", crypt_pre, 0);
  endtask
  // kdel < 0 means the core never raises crypt_ready; abort_after > 0 resets after that many results
  task automatic run_job(input logic dir, input logic [129:0] key, input logic [129:0] ekey,
                         input int nblk, input int kdel, input int lat, input int pval, input int abort_after);
    logic [127:0] data[$];
    logic [127:0] cq_d[$];
    int cq_t[$];
    int ret_t[$];
    int acc_cyc = -1, pre_cyc = -1, kr_cyc = -1, done_cyc = -1;
    int pre_n = 0, ck_n = 0, bi_n = 0, do_n = 0, iss = 0, ret = 0, di = 0;
    int exp_blk;
    bit accepted = 0, finished = 0;
    exp_blk = (kdel < 0) ? 0 : nblk;
    for (int i = 0; i < nblk; i++) data.push_back(rnd128());
    cmd_dir = dir; cmd_cmkey = key; cmd_nblk = 8'(nblk);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(posedge clk);
      #1;
      if (crypt_pre) begin
        pre_n++;
        pre_cyc = cyc;
        chk("pre_at", cyc, acc_cyc + 1);
        chk("de_cmkey", de_cmkey, key);
        chk("spurious_clr", spurious, 0);
      end
      if (pre_cyc >= 0) chk("den_sel", den_sel, dir);
      if (cmkey_valid) begin
        ck_n++;
        chk("cmkey_out", cmkey_out, ekey);
        chk("cmkey_at", cyc, kr_cyc + 1);
      end
      if (blk_in_sync) begin
        if (bi_n < nblk) chk("blk_in", blk_in, data[bi_n]);
        else chk("extra_blk_in", bi_n, nblk - 1);
        bi_n++;
        cq_d.push_back(blk_in ^ MASK);
        cq_t.push_back(cyc + lat);
      end
      if (dout_valid) begin
        if (do_n < nblk) begin
          chk("dout", dout, data[do_n] ^ MASK);
          chk("dout_at", cyc, ret_t[do_n] + 1);
          chk("dout_last", dout_last, do_n == nblk - 1);
        end else chk("extra_dout", do_n, nblk - 1);
        do_n++;
      end
      chk("din_ready", din_ready, kr_cyc >= 0 && cyc > kr_cyc && iss < nblk && iss - ret < MAXI);
      chk("inflight_max", iss - ret <= MAXI, 1);
      if (abort_after > 0 && do_n == abort_after) begin
        rst_n = 0;
        #1 check_quiet("abort");
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 check_quiet("abort_hold");
        release_reset();
        repeat (4) begin
          @(posedge clk);
          #1 chk("post_abort_quiet", {crypt_pre, blk_in_sync, done}, 0);
        end
        return;
      end
      if (done) begin
        done_cyc = cyc;
        chk("err", err, kdel < 0);
        chk("done_at", cyc, (kdel < 0) ? pre_cyc + KT + 2 : (nblk == 0) ? kr_cyc + 1 : ret_t[nblk - 1] + 1);
        chk("n_pre", pre_n, 1);
        chk("n_cmkey", ck_n, !dir && kdel >= 0);
        chk("n_blk_in", bi_n, exp_blk);
        chk("n_dout", do_n, exp_blk);
        chk("spurious_job", spurious, 0);
        finished = 1;
      end
      if (accepted) cmd_valid = 0;
      if (!accepted && cmd_ready) begin
        cmd_valid = 1;
        accepted = 1;
        acc_cyc = cyc;
      end
      crypt_ready = 0;
      en_cmkey = rnd130();
      if (pre_cyc >= 0 && kdel >= 0 && cyc == pre_cyc + kdel) begin
        crypt_ready = 1;
        en_cmkey = ekey;
        kr_cyc = cyc;
      end
      blk_out_sync = 0;
      blk_out = rnd128();
      if (cq_t.size() > 0 && cq_t[0] <= cyc) begin
        blk_out_sync = 1;
        blk_out = cq_d.pop_front();
        void'(cq_t.pop_front());
        ret_t.push_back(cyc);
        ret++;
      end
      din_valid = 0;
      din = rnd128();
      if (di < nblk && $urandom_range(99) < pval) begin
        din_valid = 1;
        din = data[di];
      end
      if (din_valid && din_ready) begin
        di++;
        iss++;
      end
    end
    if (!finished) chk("job_timeout", 0, 1);
    idle_inputs();
    @(posedge clk);
  endtask
  initial begin
    idle_inputs();
    #1 check_quiet("reset");
    chk("reset_spurious", spurious, 0);
    repeat (3) @(posedge clk);
    release_reset();
    run_job(0, rnd130(), 130'h2_DEADBEEF_00001111_22223333_44445555, 3, 20, 5, 100, 0);
    run_job(1, 130'h3_01234567_89ABCDEF_FEDCBA98_76543210, rnd130(), 3, 7, 3, 100, 0);
    run_job(0, rnd130(), rnd130(), 10, 4, 12, 100, 0);
    run_job(0, rnd130(), rnd130(), 0, 5, 5, 100, 0);
    run_job(1, rnd130(), rnd130(), 4, -1, 5, 100, 0);
    @(posedge clk);
    #1 blk_out_sync = 1;
    blk_out = rnd128();
    @(posedge clk);
    #1 blk_out_sync = 0;
    chk("spurious_set", spurious, 1);
    chk("spurious_no_dout", dout_valid, 0);
    @(posedge clk);
    #1 chk("spurious_sticky", spurious, 1);
    run_job(1, rnd130(), rnd130(), 2, 3, 4, 100, 0);
    run_job(0, rnd130(), rnd130(), 5, 3, 6, 100, 2);
    run_job(0, rnd130(), rnd130(), 5, 3, 6, 100, 0);
    for (int j = 0; j < 8; j++)
      run_job(1'($urandom_range(1)), rnd130(), rnd130(), $urandom_range(12), $urandom_range(10, 1),
              $urandom_range(15, 1), $urandom_range(100, 30), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/envelope_host_ctrl.md
# envelope_host_ctrl

Host-side sequencer that drives the digital-envelope crypto core (RSA key wrap/unwrap plus SM4 stream engine) from the opposite end of its control interface. It accepts one encrypt or decrypt job from a host port and issues the one-cycle `crypt_pre` pulse with `den_sel` and the wrapped key. It then waits for `crypt_ready`, streams N 128-bit blocks into the SM4 path with bounded in-flight tracking, and returns result blocks, the wrapped session key on encrypt, and a completion/error status.

## Interface
- `MAX_INFLIGHT`, default 4: maximum blocks issued to the core and not yet returned (1..15).
- `KEY_TIMEOUT`, default 65535: cycles allowed in WAIT_KEY before an error is declared.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host job request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_dir` in 1: 0 = encrypt, 1 = decrypt.
- `cmd_cmkey` in 130: wrapped session key; used on decrypt only.
- `cmd_nblk` in 8: number of blocks in the job (0..255).
- `din_valid` in 1: plaintext/ciphertext block offered.
- `din_ready` out 1: block accepted when `din_valid && din_ready`.
- `din` in 128: input block.
- `dout_valid` out 1: result block strobe; there is no backpressure.
- `dout` out 128: result block.
- `dout_last` out 1: qualifies the final block of the job.
- `cmkey_valid` out 1: one-cycle strobe; `cmkey_out` holds the wrapped key (encrypt only).
- `cmkey_out` out 130: captured wrapped session key.
- `done` out 1: one-cycle job completion.
- `err` out 1: qualifies `done`; 1 = key timeout.
- `spurious` out 1: sticky; a return strobe arrived with nothing in flight. Cleared on the next cmd accept.
- `crypt_pre` out 1: one-cycle start pulse to the core.
- `den_sel` out 1: direction; held stable from `crypt_pre` to the end of the job.
- `crypt_ready` in 1: core key schedule ready.
- `de_cmkey` out 130: wrapped key to the core.
- `en_cmkey` in 130: wrapped key from the core, valid in the cycle `crypt_ready` is high.
- `blk_in` out 128: block to the SM4 path.
- `blk_in_sync` out 1: block strobe.
- `blk_out` in 128: result block from the SM4 path.
- `blk_out_sync` in 1: result block strobe.

## Operation
- The FSM states are IDLE, PRE, WAIT_KEY, STREAM, DONE, ERR.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept, register `den_sel`, `de_cmkey` and `nblk`.
  - Clear the `issued` and `returned` counters (8 bit) and the `inflight` counter (4 bit). Clear `spurious`.
  - Go to PRE.
- **PRE**: `crypt_pre` = 1 for this cycle only. Clear the timer. Go to WAIT_KEY.
- **WAIT_KEY**
  - If `crypt_ready` = 1:
    - On encrypt, capture `en_cmkey` into `cmkey_out` and pulse `cmkey_valid` next cycle.
    - Go to STREAM, or to DONE if `nblk` = 0.
  - Else increment the timer. When the timer reaches `KEY_TIMEOUT`, go to ERR.
- **STREAM**
  - `din_ready` = (`issued` < `nblk`) && (`inflight` < `MAX_INFLIGHT`).
  - On a handshake: register `din` into `blk_in`, pulse `blk_in_sync` next cycle, and increment `issued`.
  - On `blk_out_sync` with `inflight` > 0: register `dout`, pulse `dout_valid`, and increment `returned`. `dout_last` = (`returned` + 1 == `nblk`).
  - `inflight` tracks registered issues minus returns. A simultaneous issue and return leaves it unchanged.
  - On `blk_out_sync` with `inflight` == 0: discard the block and set `spurious`.
  - When the last block returns, go to DONE.
- **DONE**: `done` = 1 and `err` = 0 for one cycle. Return to IDLE; `den_sel` holds its value.
- **ERR**: `done` = 1 and `err` = 1 for one cycle. Return to IDLE.
- `crypt_ready` outside WAIT_KEY is ignored.

## Timing
- **Reset values**: all outputs are 0, including `cmd_ready`. `cmd_ready` rises on the first cycle after reset deasserts. The FSM is in IDLE and the counters are 0.
- **Reset mid-job**: outputs clear immediately. No further `crypt_pre`, `blk_in_sync` or `done` is issued.
- **Start**: accept at cycle T gives `crypt_pre` at T+1, with `den_sel` and `de_cmkey` already valid at T+1.
- **Key ready**: `crypt_ready` at cycle K gives STREAM at K+1. On encrypt, `cmkey_valid` is at K+1. `din_ready` may be high at K+1.
- **Block latency**: `din` handshake at cycle H gives `blk_in_sync` at H+1. `blk_out_sync` at cycle R gives `dout_valid` at R+1.
- **Completion**: the final return at cycle L gives `dout_valid` and `dout_last` at L+1, and `done` at L+1 (coincident).
- **Empty job**: `nblk` = 0 gives `done` at K+1.
- **Key timeout**: `done`/`err` occur `KEY_TIMEOUT`+1 cycles after entering WAIT_KEY.
- **Throughput**: 1 block per cycle while `inflight` < `MAX_INFLIGHT`.

## Test plan
- **Encrypt, 3 blocks**: `cmd_dir`=0, `nblk`=3, `crypt_ready` 20 cycles after `crypt_pre`, `en_cmkey`=130'h2_DEADBEEF…, echo model with 5-cycle latency. Required:
  - one `crypt_pre`;
  - `cmkey_valid` with the matching key;
  - 3 `blk_in_sync` in order;
  - 3 `dout_valid` in order, `dout_last` on the 3rd;
  - `done`=1, `err`=0, `den_sel`=0 throughout.
- **Decrypt, key pass-through**: `cmd_dir`=1, `cmd_cmkey`=130'h3_0123… Required: `de_cmkey` equals the input at `crypt_pre`, `den_sel`=1, and no `cmkey_valid`.
- **In-flight limit**: `MAX_INFLIGHT`=4, `nblk`=10, `din_valid` always high, core latency 12. Required: `din_ready` drops after 4 issues and resumes per return; never more than 4 outstanding; 10 results.
- **Edge cases**: `nblk`=0 gives `done` the cycle after `crypt_ready`, with no block strobes. `crypt_ready` never asserted with `KEY_TIMEOUT`=50 gives `done`=`err`=1 at 51 cycles after WAIT_KEY entry.
- **Spurious return**: `blk_out_sync` with none outstanding sets `spurious` with no `dout_valid`; the next cmd accept clears it.
- **Reset mid-stream**: reset after 2 of 5 blocks; outputs clear at once. Next job completes normally.
